// File: rtl/mt_sched_pkg.sv
// Shared types and defaults for the fetch-stage thread scheduler.
// Per-thread state encoding plus the default thread count and reissue spacing.
package mt_sched_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_READY,
        T_BLOCKED,
        T_HALTED
    } thread_state_t;

    localparam int NUM_THREADS_DEF = 8;
    localparam int MIN_REISSUE_DEF = 5;

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// Combinational rotating-priority picker: returns the first set mask bit
// after ptr, wrapping around, so ptr itself has the lowest priority.
module rr_picker #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] pick,
    output logic         any
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        pick = ptr;
        any  = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (mask[ptr + W'(i)]) begin
                pick = ptr + W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Fetch-stage round-robin thread scheduler: tracks per-thread state, block
// timers and issue cooldown, and registers the next fetch thread id.
module thread_scheduler
    import mt_sched_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int SEL_W       = 3,
    parameter int MIN_REISSUE = MIN_REISSUE_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   block_valid,
    input  logic [SEL_W-1:0]       block_tid,
    input  logic [CNT_W-1:0]       block_cycles,
    input  logic                   halt_valid,
    input  logic [SEL_W-1:0]       halt_tid,
    output logic [SEL_W-1:0]       sel_f,
    output logic                   issue_valid,
    output logic [NUM_THREADS-1:0] ready_mask,
    output logic                   all_halted
);

    localparam int CD_W = (MIN_REISSUE > 2) ? $clog2(MIN_REISSUE) : 1;

    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] done;
    logic [SEL_W-1:0]       pick;
    logic                   any;
    logic [CNT_W-1:0]       blk_load;
    logic [SEL_W-1:0]       sel_q, sel_d, ptr_q, ptr_d;
    logic                   valid_q, valid_d;

    assign blk_load = (block_cycles == '0) ? CNT_W'(1) : block_cycles;

    rr_picker #(
        .N (NUM_THREADS),
        .W (SEL_W)
    ) u_picker (
        .mask (eligible),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        thread_state_t    state_q, state_d;
        logic [CNT_W-1:0] blk_q, blk_d;
        logic [CD_W-1:0]  cd_q, cd_d;
        logic             halt_hit, block_hit;

        assign halt_hit  = halt_valid  && (halt_tid  == SEL_W'(gi));
        assign block_hit = block_valid && (block_tid == SEL_W'(gi));

        // Disable beats everything; halt beats block; a fresh block beats expiry.
        always_comb begin
            state_d = state_q;
            blk_d   = blk_q;
            cd_d    = (cd_q != '0) ? cd_q - CD_W'(1) : cd_q;
            if (any && (pick == SEL_W'(gi))) begin
                cd_d = CD_W'(MIN_REISSUE - 1);
            end
            if (!thread_en[gi]) begin
                state_d = T_IDLE;
                blk_d   = '0;
                cd_d    = '0;
            end else begin
                case (state_q)
                    T_IDLE:  state_d = T_READY;
                    T_READY: begin
                        if (halt_hit) begin
                            state_d = T_HALTED;
                        end else if (block_hit) begin
                            state_d = T_BLOCKED;
                            blk_d   = blk_load;
                        end
                    end
                    T_BLOCKED: begin
                        if (halt_hit) begin
                            state_d = T_HALTED;
                            blk_d   = '0;
                        end else if (block_hit) begin
                            blk_d = blk_load;
                        end else if (blk_q <= CNT_W'(1)) begin
                            state_d = T_READY;
                            blk_d   = '0;
                        end else begin
                            blk_d = blk_q - CNT_W'(1);
                        end
                    end
                    T_HALTED: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= T_IDLE;
                blk_q   <= '0;
                cd_q    <= '0;
            end else begin
                state_q <= state_d;
                blk_q   <= blk_d;
                cd_q    <= cd_d;
            end
        end

        assign eligible[gi] = (state_q == T_READY) && (cd_q == '0);
        assign done[gi]     = !thread_en[gi] || (state_q == T_HALTED);
    end

    always_comb begin
        valid_d = any;
        sel_d   = any ? pick : sel_q;
        ptr_d   = any ? pick : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SEL_W'(NUM_THREADS - 1);
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel_f       = sel_q;
    assign issue_valid = valid_q;
    assign ready_mask  = eligible;
    assign all_halted  = (&done) && (|thread_en);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed and randomized stimulus for thread_scheduler, checked every cycle
// against a reference model based on issue timestamps and release deadlines.
module tb_thread_scheduler;

    localparam int N  = 8;
    localparam int MR = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] thread_en = '0;
    logic       block_valid = 1'b0;
    logic [2:0] block_tid = '0;
    logic [7:0] block_cycles = '0;
    logic       halt_valid = 1'b0;
    logic [2:0] halt_tid = '0;
    logic [2:0] sel_f;
    logic       issue_valid;
    logic [7:0] ready_mask;
    logic       all_halted;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    thread_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .thread_en    (thread_en),
        .block_valid  (block_valid),
        .block_tid    (block_tid),
        .block_cycles (block_cycles),
        .halt_valid   (halt_valid),
        .halt_tid     (halt_tid),
        .sel_f        (sel_f),
        .issue_valid  (issue_valid),
        .ready_mask   (ready_mask),
        .all_halted   (all_halted)
    );

    // Reference model: a thread may issue once MR edges have passed since its
    // last issue; a blocked thread wakes on the edge index stored in m_release.
    typedef enum int {M_IDLE, M_READY, M_BLOCKED, M_HALTED} mstate_e;
    mstate_e m_st [N];
    int      m_release [N];
    int      m_last [N];
    int      m_ptr, m_sel, edge_k;
    bit      m_valid;

    function automatic bit m_elig(int t, int k);
        return (m_st[t] == M_READY) && ((k - m_last[t]) >= MR);
    endfunction

    function automatic void m_init();
        for (int t = 0; t < N; t++) begin
            m_st[t]      = M_IDLE;
            m_release[t] = 0;
            m_last[t]    = -1000;
        end
        m_ptr   = N - 1;
        m_sel   = 0;
        m_valid = 1'b0;
    endfunction

    function automatic void m_edge();
        bit found;
        int p;
        int blen;
        edge_k++;
        if (reset) begin
            m_init();
            return;
        end
        found = 1'b0;
        p     = m_ptr;
        for (int off = 1; off <= N; off++) begin
            if (!found && m_elig((m_ptr + off) % N, edge_k)) begin
                found = 1'b1;
                p     = (m_ptr + off) % N;
            end
        end
        m_valid = found;
        if (found) begin
            m_sel     = p;
            m_ptr     = p;
            m_last[p] = edge_k;
        end
        blen = (block_cycles == 0) ? 1 : int'(block_cycles);
        for (int t = 0; t < N; t++) begin
            bit h, b;
            h = halt_valid  && (int'(halt_tid)  == t);
            b = block_valid && (int'(block_tid) == t);
            if (!thread_en[t]) begin
                m_st[t]   = M_IDLE;
                m_last[t] = -1000;
            end else begin
                case (m_st[t])
                    M_IDLE:  m_st[t] = M_READY;
                    M_READY: begin
                        if (h) m_st[t] = M_HALTED;
                        else if (b) begin
                            m_st[t]      = M_BLOCKED;
                            m_release[t] = edge_k + blen;
                        end
                    end
                    M_BLOCKED: begin
                        if (h) m_st[t] = M_HALTED;
                        else if (b) m_release[t] = edge_k + blen;
                        else if (edge_k >= m_release[t]) m_st[t] = M_READY;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic logic [7:0] m_ready();
        logic [7:0] r;
        for (int t = 0; t < N; t++) r[t] = m_elig(t, edge_k + 1);
        return r;
    endfunction

    function automatic bit m_all_halted();
        bit any_en, all_h;
        any_en = 1'b0;
        all_h  = 1'b1;
        for (int t = 0; t < N; t++) begin
            if (thread_en[t]) begin
                any_en = 1'b1;
                if (m_st[t] != M_HALTED) all_h = 1'b0;
            end
        end
        return any_en && all_h;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        $display("edge %0d rst=%0b en=%h blk=%0b/%0d/%0d hlt=%0b/%0d -> sel=%0d v=%0b rdy=%h ah=%0b",
                 edge_k, reset, thread_en, block_valid, block_tid, block_cycles,
                 halt_valid, halt_tid, sel_f, issue_valid, ready_mask, all_halted);
        chk_eq("issue_valid", 32'(issue_valid), 32'(m_valid));
        if (m_valid) chk_eq("sel_f", 32'(sel_f), 32'(m_sel));
        else         chk_eq("sel_f_hold", 32'(sel_f), 32'(m_sel));
        chk_eq("ready_mask", 32'(ready_mask), 32'(m_ready()));
        chk_eq("all_halted", 32'(all_halted), 32'(m_all_halted()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_block(input int tid, input int cyc);
        block_valid  = 1'b1;
        block_tid    = 3'(tid);
        block_cycles = 8'(cyc);
        step();
        block_valid  = 1'b0;
    endtask

    task automatic pulse_halt(input int tid);
        halt_valid = 1'b1;
        halt_tid   = 3'(tid);
        step();
        halt_valid = 1'b0;
    endtask

    initial begin
        edge_k = 0;
        m_init();

        // Full rotation with every thread enabled.
        run(2);
        thread_en = 8'hFF;
        run(1);
        reset = 1'b0;
        run(2);
        chk_eq("first_issue_valid", 32'(issue_valid), 32'd1);
        chk_eq("first_issue_sel", 32'(sel_f), 32'd0);
        run(10);

        // Single thread: issue every MR cycles.
        thread_en = 8'h01;
        run(16);

        // Four threads with thread 2 blocked for 10 cycles.
        thread_en = 8'h0F;
        run(4);
        pulse_block(2, 10);
        run(20);

        // Halt and block on the same thread in one cycle, then halt the rest.
        halt_valid   = 1'b1;
        halt_tid     = 3'd1;
        block_valid  = 1'b1;
        block_tid    = 3'd1;
        block_cycles = 8'd7;
        step();
        halt_valid   = 1'b0;
        block_valid  = 1'b0;
        run(6);
        pulse_halt(0);
        pulse_halt(2);
        pulse_halt(3);
        run(5);
        chk_eq("all_halted_final", 32'(all_halted), 32'd1);

        // Zero-length block and a block on an idle thread.
        thread_en = 8'h00;
        run(1);
        thread_en = 8'h01;
        run(3);
        pulse_block(0, 0);
        run(6);
        pulse_block(5, 9);
        run(6);

        // Reset while a long block is pending.
        thread_en = 8'hFF;
        run(4);
        pulse_block(4, 50);
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(10);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) thread_en = 8'($urandom);
            block_valid  = ($urandom_range(0, 5) == 0);
            block_tid    = 3'($urandom);
            block_cycles = 8'($urandom_range(0, 12));
            halt_valid   = ($urandom_range(0, 39) == 0);
            halt_tid     = 3'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
